// File: rtl/dcache_assoc.sv
// One- or two-way set-associative, write-through, no-write-allocate data cache with counted burst refill.
// Optional whole-cache invalidate (flush port, FLUSH state) is compiled in by DCACHE_ASSOC_FLUSH_EN.
module dcache_assoc #(
  parameter int IDX_W = 6,
  parameter int OFS_W = 4,
  parameter int WAYS  = 2,
  localparam int TAG_W = 30 - IDX_W - OFS_W
) (
  input  logic        clock,
  input  logic        reset,
`ifdef DCACHE_ASSOC_FLUSH_EN
  input  logic        flush,
`endif
  input  logic        PStrobe,
  input  logic        PRw,
  input  logic [31:0] PAddress,
  input  logic [31:0] PData_out,
  output logic [31:0] PData_in,
  output logic        CReady,
  output logic        SysStrobe,
  output logic        SysRW,
  output logic [31:0] SysAddress,
  output logic [31:0] SysData_in,
  input  logic [31:0] SysData_out,
  input  logic        SysAck,
  input  logic        SysReady
);
  localparam int SETS  = 1 << IDX_W;
  localparam int WORDS = 1 << OFS_W;

  // Handshakes: the CPU holds PStrobe with PRw/PAddress/PData_out until a one-cycle
  // CReady; the request is latched when accepted, so it completes even if PStrobe drops.
  // On the bus, SysStrobe is held for the whole transaction: a read burst takes one word
  // per SysAck cycle (WORDS of them), a single-word write ends on the SysReady cycle.
  typedef enum logic [2:0] {
    S_IDLE,
    S_REFILL,
    S_WRITE,
    S_RESP
`ifdef DCACHE_ASSOC_FLUSH_EN
    , S_FLUSH
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [SETS-1:0]   valid_q [WAYS];
  logic [SETS-1:0]   lru_q;
  logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
  logic [31:0]       data_q  [WAYS][SETS][WORDS];

  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [OFS_W-1:0]  count_q;
  logic              victim_q;

  logic              flush_req;
`ifdef DCACHE_ASSOC_FLUSH_EN
  logic [IDX_W-1:0]  flush_cnt_q;
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  // In IDLE the lookup uses the live CPU address; afterwards the latched request.
  logic [31:0]       cur_addr;
  logic [TAG_W-1:0]  cur_tag;
  logic [IDX_W-1:0]  cur_idx;
  logic [OFS_W-1:0]  cur_word;

  assign cur_addr = (state_q == S_IDLE) ? PAddress : addr_q;
  assign cur_tag  = cur_addr[31:OFS_W+IDX_W+2];
  assign cur_idx  = cur_addr[OFS_W+IDX_W+1:OFS_W+2];
  assign cur_word = cur_addr[OFS_W+1:2];

  logic hit;
  logic hit_way;
  logic victim;
  logic way1_valid;

  always_comb begin
    hit     = 1'b0;
    hit_way = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][cur_idx] && (tag_q[w][cur_idx] == cur_tag)) begin
        hit     = 1'b1;
        hit_way = w[0];
      end
    end
  end

  // lru_q holds the least-recently-used way of each set.
  assign way1_valid = (WAYS > 1) ? valid_q[WAYS-1][cur_idx] : 1'b1;

  always_comb begin
    if ((WAYS == 1) || !valid_q[0][cur_idx]) victim = 1'b0;
    else if (!way1_valid)                    victim = 1'b1;
    else                                     victim = lru_q[cur_idx];
  end

  logic accept;
  logic rd_hit;
  logic wr_hit;
  logic refill_ack;
  logic refill_last;

  assign accept      = (state_q == S_IDLE) && !flush_req && PStrobe;
  assign rd_hit      = accept && PRw && hit;
  assign wr_hit      = accept && !PRw && hit;
  assign refill_ack  = (state_q == S_REFILL) && SysAck;
  assign refill_last = refill_ack && (&count_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    CReady     = 1'b0;
    SysStrobe  = 1'b0;
    SysRW      = 1'b1;
    SysAddress = '0;
    unique case (state_q)
      S_IDLE: begin
`ifdef DCACHE_ASSOC_FLUSH_EN
        if (flush_req) state_d = S_FLUSH;
        else
`endif
        if (PStrobe) begin
          if (!PRw)     state_d = S_WRITE;
          else if (hit) state_d = S_RESP;
          else          state_d = S_REFILL;
        end
      end
      S_REFILL: begin
        SysStrobe  = 1'b1;
        SysAddress = {addr_q[31:OFS_W+2], {(OFS_W+2){1'b0}}};
        if (refill_last) state_d = S_RESP;
      end
      S_WRITE: begin
        SysStrobe  = 1'b1;
        SysRW      = 1'b0;
        SysAddress = addr_q;
        if (SysReady) state_d = S_RESP;
      end
      S_RESP: begin
        CReady  = 1'b1;
        state_d = S_IDLE;
      end
`ifdef DCACHE_ASSOC_FLUSH_EN
      S_FLUSH: begin
        if (&flush_cnt_q) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign PData_in   = rdata_q;
  assign SysData_in = wdata_q;

  // Control state: valid/LRU bits, request latch, burst counter and read data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
      lru_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      count_q  <= '0;
      victim_q <= 1'b0;
`ifdef DCACHE_ASSOC_FLUSH_EN
      flush_cnt_q <= '0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
`ifdef DCACHE_ASSOC_FLUSH_EN
          if (flush_req) flush_cnt_q <= '0;
`endif
          if (accept) begin
            addr_q  <= PAddress;
            wdata_q <= PData_out;
            count_q <= '0;
            if (hit) begin
              if (WAYS > 1) lru_q[cur_idx] <= ~hit_way;
              if (PRw) rdata_q <= data_q[hit_way][cur_idx][cur_word];
            end else if (PRw) begin
              victim_q                 <= victim;
              valid_q[victim][cur_idx] <= 1'b0;
            end
          end
        end
        S_REFILL: begin
          if (refill_ack) begin
            count_q <= count_q + 1'b1;
            if (count_q == cur_word) rdata_q <= SysData_out;
            if (refill_last) begin
              valid_q[victim_q][cur_idx] <= 1'b1;
              if (WAYS > 1) lru_q[cur_idx] <= ~victim_q;
            end
          end
        end
`ifdef DCACHE_ASSOC_FLUSH_EN
        S_FLUSH: begin
          for (int w = 0; w < WAYS; w++) valid_q[w][flush_cnt_q] <= 1'b0;
          lru_q[flush_cnt_q] <= 1'b0;
          flush_cnt_q        <= flush_cnt_q + 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  // Tag and data arrays carry no reset; valid bits alone qualify their contents.
  always_ff @(posedge clock) begin
    if (wr_hit)      data_q[hit_way][cur_idx][cur_word] <= PData_out;
    if (refill_ack)  data_q[victim_q][cur_idx][count_q] <= SysData_out;
    if (refill_last) tag_q[victim_q][cur_idx]           <= cur_tag;
  end

endmodule

// File: tb/tb_dcache_assoc.sv
// Directed bench for dcache_assoc: bus responder model, CPU access task, hand-computed expectations.
// Set DCACHE_ASSOC_FLUSH_EN to include the flush port and its test.
module tb_dcache_assoc;
  localparam int WORDS = 16;

  // clock / reset
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        PStrobe, PRw;
  logic [31:0] PAddress, PData_out, PData_in;
  logic        CReady, SysStrobe, SysRW;
  logic [31:0] SysAddress, SysData_in;
  logic [31:0] SysData_out = '0;
  logic        SysAck = 1'b0;
  logic        SysReady = 1'b0;
`ifdef DCACHE_ASSOC_FLUSH_EN
  logic        flush;
`endif

  dcache_assoc dut (
    .clock      (clock),
    .reset      (reset),
`ifdef DCACHE_ASSOC_FLUSH_EN
    .flush      (flush),
`endif
    .PStrobe    (PStrobe),
    .PRw        (PRw),
    .PAddress   (PAddress),
    .PData_out  (PData_out),
    .PData_in   (PData_in),
    .CReady     (CReady),
    .SysStrobe  (SysStrobe),
    .SysRW      (SysRW),
    .SysAddress (SysAddress),
    .SysData_in (SysData_in),
    .SysData_out(SysData_out),
    .SysAck     (SysAck),
    .SysReady   (SysReady)
  );

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // bus responder: burst acks carry ack_base+i, writes complete after wr_delay strobe cycles
  logic [31:0] ack_base  = '0;
  int          ack_limit = WORDS;
  int          wr_delay  = 3;
  int          bus_cnt   = 0;
  int          wr_wait   = 0;
  int          total_acks = 0;
  int          total_strobe = 0;
  logic [31:0] bus_addr  = '0;
  logic [31:0] bus_wdata = '0;
  logic        bus_rw    = 1'b1;

  always @(negedge clock) begin
    SysAck   = 1'b0;
    SysReady = 1'b0;
    if (SysStrobe) begin
      total_strobe++;
      bus_addr = SysAddress;
      bus_rw   = SysRW;
      if (SysRW) begin
        if (bus_cnt < ack_limit) begin
          SysAck      = 1'b1;
          SysData_out = ack_base + 32'(bus_cnt);
          bus_cnt++;
          total_acks++;
        end
      end else begin
        bus_wdata = SysData_in;
        wr_wait++;
        if (wr_wait >= wr_delay) SysReady = 1'b1;
      end
    end else begin
      bus_cnt = 0;
      wr_wait = 0;
    end
  end

  // driver: one CPU access, returns latency in cycles, read data and bus activity
  task automatic access(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                        output int cycles, output logic [31:0] rdata,
                        output int acks, output int strobes);
    int a0, s0;
    a0 = total_acks;
    s0 = total_strobe;
    PStrobe   = 1'b1;
    PRw       = rw;
    PAddress  = addr;
    PData_out = wdata;
    cycles    = 0;
    while (cycles < 200) begin
      @(negedge clock);
      cycles++;
      if (CReady) break;
    end
    rdata = PData_in;
    check("cready_seen", CReady, 1'b1);
    PStrobe = 1'b0;
    @(negedge clock);
    acks    = total_acks - a0;
    strobes = total_strobe - s0;
  endtask

  task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] exp_data,
                    input int exp_cycles, input int exp_acks);
    int cyc, acks, strobes;
    logic [31:0] data;
    access(1'b1, addr, 32'h0, cyc, data, acks, strobes);
    check({name, "_data"}, data, exp_data);
    check({name, "_cycles"}, cyc, exp_cycles);
    check({name, "_acks"}, acks, exp_acks);
    if (exp_acks == 0) check({name, "_nostrobe"}, strobes, 0);
  endtask

  task automatic wr(input string name, input logic [31:0] addr, input logic [31:0] data);
    int cyc, acks, strobes;
    logic [31:0] rdata;
    access(1'b0, addr, data, cyc, rdata, acks, strobes);
    check({name, "_cycles"}, cyc, 4);
    check({name, "_addr"}, bus_addr, addr);
    check({name, "_rw"}, bus_rw, 1'b0);
    check({name, "_wdata"}, bus_wdata, data);
    check({name, "_acks"}, acks, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    PStrobe = 1'b0; PRw = 1'b1; PAddress = '0; PData_out = '0;
`ifdef DCACHE_ASSOC_FLUSH_EN
    flush = 1'b0;
`endif
    repeat (2) @(negedge clock);
    check("rst_cready", CReady, 1'b0);
    check("rst_sysstrobe", SysStrobe, 1'b0);
    check("rst_sysrw", SysRW, 1'b1);
    check("rst_sysaddr", SysAddress, 32'h0);
    check("rst_pdata", PData_in, 32'h0);
    reset = 1'b1;
    @(negedge clock);

    // read miss with 16-word burst, then a hit in the same line
    ack_base = 32'hA000_0000;
    rd("miss1048", 32'h0000_1048, 32'hA000_0002, 17, 16);
    check("miss1048_busaddr", bus_addr, 32'h0000_1040);
    check("miss1048_busrw", bus_rw, 1'b1);
    rd("hit104c", 32'h0000_104C, 32'hA000_0003, 1, 0);

    // write hit updates the line and goes through to the bus
    wr("wrhit1044", 32'h0000_1044, 32'h1234_5678);
    rd("hit1044", 32'h0000_1044, 32'h1234_5678, 1, 0);

    // write miss allocates nothing
    ack_base = 32'hB000_0000;
    wr("wrmiss2000", 32'h0000_2000, 32'hCAFE_0001);
    rd("miss2000", 32'h0000_2000, 32'hB000_0000, 17, 16);
    check("miss2000_busaddr", bus_addr, 32'h0000_2000);

    // two-way LRU in set 1: 0x1040 in way0, 0x2040 fills way1, hit 0x1040, 0x3040 evicts 0x2040
    ack_base = 32'hC000_0000;
    rd("fill2040", 32'h0000_2040, 32'hC000_0000, 17, 16);
    rd("hit1040a", 32'h0000_1040, 32'hA000_0000, 1, 0);
    ack_base = 32'hD000_0000;
    rd("fill3040", 32'h0000_3040, 32'hD000_0000, 17, 16);
    rd("hit1040b", 32'h0000_1040, 32'hA000_0000, 1, 0);
    rd("hit3040", 32'h0000_3040, 32'hD000_0000, 1, 0);
    ack_base = 32'hE000_0000;
    rd("miss2040", 32'h0000_2040, 32'hE000_0000, 17, 16);

    // async reset after 5th ack aborts the refill
    ack_base  = 32'hF000_0000;
    ack_limit = 5;
    PStrobe = 1'b1; PRw = 1'b1; PAddress = 32'h0000_5080;
    for (int i = 0; i < 50 && bus_cnt < 5; i++) @(negedge clock);
    check("abort_acks", bus_cnt, 5);
    @(posedge clock);
    #2;
    check("abort_strobe_before", SysStrobe, 1'b1);
    reset = 1'b0;
    #1;
    check("abort_strobe_after", SysStrobe, 1'b0);
    check("abort_cready", CReady, 1'b0);
    check("abort_pdata", PData_in, 32'h0);
    PStrobe = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    ack_limit = WORDS;
    @(negedge clock);
    rd("refill5080", 32'h0000_5080, 32'hF000_0000, 17, 16);
    ack_base = 32'h1100_0000;
    rd("miss1040_after_rst", 32'h0000_1040, 32'h1100_0000, 17, 16);

`ifdef DCACHE_ASSOC_FLUSH_EN
    begin
      int n_cr;
      rd("hit1040_pre_flush", 32'h0000_1040, 32'h1100_0000, 1, 0);
      flush = 1'b1;
      @(negedge clock);
      flush = 1'b0;
      n_cr = 0;
      repeat (66) begin
        @(negedge clock);
        if (CReady) n_cr++;
      end
      check("flush_no_cready", n_cr, 0);
      ack_base = 32'h2200_0000;
      rd("miss1040_after_flush", 32'h0000_1040, 32'h2200_0000, 17, 16);
    end
`endif

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/dcache_assoc.md
Name: dcache_assoc

Overview:
- Parametrised successor to the direct-mapped, write-through data cache.
- Configurable set count and line length, with 1 or 2 ways.
- Two-way mode uses per-set LRU replacement; refill is a counted multi-word burst.
- Sits between the CPU data port (P*) and the system bus (Sys*); write-through, no-write-allocate.

Parameters:
IDX_W, 6, index bits; SETS = 2^IDX_W
OFS_W, 4, word-offset bits; WORDS = 2^OFS_W words per line
WAYS, 2, associativity; legal values 1 or 2
TAG_W, 30-IDX_W-OFS_W, derived; not overridden

Ports:
clock  input  1  sole clock, rising edge
reset  input  1  asynchronous, active-low reset
PStrobe  input  1  CPU request; held with PRw/PAddress/PData_out until CReady
PRw  input  1  1=read, 0=write
PAddress  input  32  byte address; [1:0] ignored
PData_out  input  32  CPU write data
PData_in  output  32  read data, valid while CReady=1
CReady  output  1  one-cycle completion pulse
SysStrobe  output  1  bus request, held until transaction ends
SysRW  output  1  1=read burst, 0=single-word write
SysAddress  output  32  read: line base (offset bits zeroed); write: PAddress
SysData_in  output  32  bus write data (=PData_out)
SysData_out  input  32  bus read data, sampled when SysAck=1
SysAck  input  1  one refill word valid this cycle
SysReady  input  1  write complete

Behaviour:
- Address split: tag=[31:OFS_W+IDX_W+2], index=[OFS_W+IDX_W+1:OFS_W+2], word=[OFS_W+1:2].
- Per set, per way: valid, tag, WORDS data words. One LRU bit per set, used only when WAYS=2.
- Reset (async, low):
  - All valid and LRU bits clear; state IDLE.
  - CReady=0, SysStrobe=0, SysRW=1, SysAddress=0, PData_in=0.
  - Reset mid-transaction aborts it at once; SysStrobe drops without waiting for a clock; the line being filled stays invalid.
- States: IDLE, REFILL, WRITE, RESP, plus FLUSH if the optional feature is enabled.
- IDLE, PStrobe=1 sampled:
  - Read hit: latch word; next cycle RESP.
  - Read miss: REFILL.
  - Write: WRITE. On a hit, update the hit way's word in this cycle and mark that way MRU.
- REFILL:
  - Victim way: first invalid way (way0 preferred), else the LRU way.
  - Clear victim valid on entry.
  - SysStrobe=1, SysRW=1, SysAddress=line base.
  - Each SysAck writes SysData_out to victim[count]; count starts at 0 and increments per ack.
  - On the WORDS-th ack: set tag and valid, victim becomes MRU, latch the requested word, go to RESP. SysStrobe is low from the next cycle.
- WRITE:
  - SysStrobe=1, SysRW=0, SysAddress=PAddress, SysData_in=PData_out.
  - On SysReady, go to RESP.
  - A write miss allocates nothing.
- RESP: CReady=1 for exactly one cycle and PData_in is valid; PStrobe is ignored; return to IDLE. Minimum read-hit turnaround is therefore 2 cycles.
- Latency:
  - Read hit: CReady one cycle after the strobe is sampled.
  - Miss: CReady one cycle after the last ack.
- Boundary conditions:
  - SysAck outside REFILL and SysReady outside WRITE are ignored.
  - Simultaneous SysAck and SysReady in REFILL: SysReady is ignored.
  - PStrobe dropped mid-transaction: the transaction still completes.
  - WAYS=1: way0 is always the victim; LRU is unused.

Optional Feature:
- Macro DCACHE_ASSOC_FLUSH_EN.
- When defined:
  - Adds input port flush (1 bit).
  - flush=1 sampled in IDLE takes priority over PStrobe and enters FLUSH.
  - FLUSH clears valid and LRU for set 0..SETS-1, one set per cycle (SETS cycles), then returns to IDLE.
  - PStrobe is not accepted until FLUSH completes; CReady is not pulsed for a flush.
- When undefined: no flush port and no FLUSH state.

Test Plan:
1. Reset, then read 0x0000_1048 → SysAddress=0x0000_1040, SysRW=1; supply 16 acks with data 0xA000_0000+i → CReady, PData_in=0xA000_0002. Then read 0x104C → hit one cycle later with 0xA000_0003 and no SysStrobe.
2. After 1, write 0x1044 with 0x1234_5678; SysReady after 3 cycles → SysRW=0, SysData_in=0x1234_5678, then CReady. A following read of 0x1044 hits with 0x1234_5678.
3. Write miss to 0x2000 → bus write only. A following read of 0x2000 misses and does a full 16-ack refill.
4. WAYS=2, index 1: fill 0x1040, then 0x2040; read 0x1040 (hit); fill 0x3040 (evicts 0x2040). Then 0x1040 hits and 0x2040 misses.
5. Assert reset after the 5th ack of a refill → SysStrobe falls asynchronously. After release, a read of the same address requires a full 16-ack refill.
6. DCACHE_ASSOC_FLUSH_EN: fill 0x1040, pulse flush → 64 cycles with no CReady. Then a read of 0x1040 misses.
